// File: rtl/main_ctrl_fsm.sv
// Multi-cycle MIPS-style main control FSM: sequences fetch/decode/execute/memory/writeback
// and emits datapath control strobes decoded from the current state.
module main_ctrl_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNot,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] AluOp,
  output logic [3:0] State,
  output logic       IllegalOp
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC_R = 4'd6,  RWB    = 4'd7,
    BRANCH = 4'd8,  JUMP   = 4'd9,  EXEC_I = 4'd10, IWB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BGTZ = 6'b000111;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  state_t     state;
  logic [5:0] op_q;

  // op_q is captured in DECODE so later states are immune to Opcode changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      IllegalOp <= 1'b0;
      op_q      <= 6'd0;
    end else begin
      case (state)
        FETCH:  if (MemReady) state <= DECODE;
        DECODE: begin
          op_q <= Opcode;
          case (Opcode)
            OP_R:                             state <= EXEC_R;
            OP_LW, OP_SW:                     state <= MEMADR;
            OP_BEQ, OP_BNE, OP_BGTZ:          state <= BRANCH;
            OP_J:                             state <= JUMP;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state <= EXEC_I;
            default: begin
              state     <= FETCH;
              IllegalOp <= 1'b1;
            end
          endcase
        end
        MEMADR: state <= (op_q == OP_SW) ? MEMWR : MEMRD;
        MEMRD:  if (MemReady) state <= MEMWB;
        MEMWB:  state <= FETCH;
        MEMWR:  if (MemReady) state <= FETCH;
        EXEC_R: state <= RWB;
        RWB:    state <= FETCH;
        BRANCH: state <= FETCH;
        JUMP:   state <= FETCH;
        EXEC_I: state <= IWB;
        IWB:    state <= FETCH;
        default: begin
          state     <= FETCH;
          IllegalOp <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNot   = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSrc       = 2'b00;
    AluOp       = 3'b000;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      DECODE: ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXEC_R: begin
        ALUSrcA = 1'b1;
        AluOp   = 3'b010;
      end
      RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        PCWriteCond = 1'b1;
        PCSrc       = 2'b01;
        AluOp       = (op_q == OP_BGTZ) ? 3'b110 : 3'b001;
        BranchNot   = (op_q != OP_BEQ);
      end
      JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b10;
      end
      EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (op_q)
          OP_ANDI: AluOp = 3'b100;
          OP_ORI:  AluOp = 3'b101;
          OP_SLTI: AluOp = 3'b111;
          default: AluOp = 3'b000;
        endcase
      end
      IWB:     RegWrite = 1'b1;
      default: ;
    endcase
  end

  assign State = state;

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Scoreboard bench for main_ctrl_fsm: stimulus pushes per-cycle expected outputs derived
// from instruction-level state paths; a negedge monitor pops and compares.
module tb_main_ctrl_fsm;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] Opcode;
  logic MemReady;
  logic PCWrite, PCWriteCond, BranchNot, IorD, MemRead, MemWrite, IRWrite;
  logic MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] AluOp;
  logic [3:0] State;

  main_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNot(BranchNot),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .AluOp(AluOp), .State(State),
    .IllegalOp(IllegalOp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       ill;
    logic       pcw, pcwc, bn, iord, mrd, mwr, irw, m2r, rdst, rwr, asa;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
  } out_t;

  out_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [5:0] m_lop = 6'd0;
  logic       m_ill = 1'b0;

  // Expected outputs written straight from the per-state output table.
  function automatic out_t exp_out(input int st, input logic [5:0] lop,
                                   input logic mr, input logic ill);
    out_t o = '0;
    o.st  = st[3:0];
    o.ill = ill;
    case (st)
      0:  begin o.mrd = 1; o.asb = 2'b01; o.irw = mr; o.pcw = mr; end
      1:  o.asb = 2'b11;
      2:  begin o.asa = 1; o.asb = 2'b10; end
      3:  begin o.mrd = 1; o.iord = 1; end
      4:  begin o.rwr = 1; o.m2r = 1; end
      5:  begin o.mwr = 1; o.iord = 1; end
      6:  begin o.asa = 1; o.aop = 3'b010; end
      7:  begin o.rwr = 1; o.rdst = 1; end
      8:  begin
            o.asa = 1; o.pcwc = 1; o.pcs = 2'b01;
            o.aop = (lop == 6'b000111) ? 3'b110 : 3'b001;
            o.bn  = (lop != 6'b000100);
          end
      9:  begin o.pcw = 1; o.pcs = 2'b10; end
      10: begin
            o.asa = 1; o.asb = 2'b10;
            case (lop)
              6'b001100: o.aop = 3'b100;
              6'b001101: o.aop = 3'b101;
              6'b001010: o.aop = 3'b111;
              default:   o.aop = 3'b000;
            endcase
          end
      11: o.rwr = 1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic out_t act_out();
    out_t a;
    a = {State, IllegalOp, PCWrite, PCWriteCond, BranchNot, IorD, MemRead, MemWrite,
         IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSrc, AluOp};
    return a;
  endfunction

  // Monitor: every cycle the DUT presents a full output vector.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t e, a;
      e = exp_q.pop_front();
      a = act_out();
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL outputs @%0t: got st=%0d ill=%b vec=%h, want st=%0d ill=%b vec=%h",
                 $time, a.st, a.ill, a, e.st, e.ill, e);
      end
    end
  end

  task automatic cyc(input logic [5:0] op, input logic mr, input int st, input logic rst);
    @(posedge clk);
    #1;
    rst_n = rst; Opcode = op; MemReady = mr;
    exp_q.push_back(exp_out(st, m_lop, mr, m_ill));
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // One instruction: fetch (with optional stall), decode, then the opcode's state path.
  task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall, input bit chg);
    int path[$];
    logic [5:0] oth;
    for (int i = 0; i <= fstall; i++)
      cyc(6'($urandom_range(0, 63)), (i == fstall), 0, 1'b1);
    cyc(op, 1'($urandom_range(0, 1)), 1, 1'b1);
    m_lop = op;
    case (op)
      6'b000000:                                 path = '{6, 7};
      6'b100011:                                 path = '{2, 3, 4};
      6'b101011:                                 path = '{2, 5};
      6'b000100, 6'b000101, 6'b000111:          path = '{8};
      6'b000010:                                 path = '{9};
      6'b001000, 6'b001100, 6'b001101, 6'b001010: path = '{10, 11};
      default: begin path = {}; m_ill = 1'b1; end
    endcase
    foreach (path[k]) begin
      oth = chg ? 6'($urandom_range(0, 63)) : op;
      if (path[k] == 3 || path[k] == 5) begin
        for (int w = 0; w < mstall; w++) cyc(oth, 1'b0, path[k], 1'b1);
        cyc(oth, 1'b1, path[k], 1'b1);
      end else begin
        cyc(oth, 1'($urandom_range(0, 1)), path[k], 1'b1);
      end
    end
  endtask

  logic [5:0] legal [11] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h07,
                             6'h02, 6'h08, 6'h0c, 6'h0d, 6'h0a};

  task automatic random_instrs(input int n);
    logic [5:0] op;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) < 8) op = legal[$urandom_range(0, 10)];
      else op = 6'($urandom_range(0, 63));
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rst_n = 1'b0; Opcode = 6'd0; MemReady = 1'b1;
    #2;
    check("reset_state", {4'd0, State}, 8'd0);
    check("reset_illegal", {7'd0, IllegalOp}, 8'd0);
    cyc(6'd0, 1'b1, 0, 1'b0);
    cyc(6'd0, 1'b0, 0, 1'b0);

    run_instr(6'b100011, 0, 0, 1'b0);   // lw: 0,1,2,3,4
    run_instr(6'b001000, 3, 0, 1'b0);   // fetch stall 3 cycles, addi
    run_instr(6'b000111, 0, 0, 1'b0);   // bgtz: 0,1,8
    run_instr(6'b001101, 0, 0, 1'b1);   // ori with opcode changing after decode
    run_instr(6'b000101, 1, 0, 1'b1);   // bne
    run_instr(6'b000100, 0, 0, 1'b0);   // beq
    run_instr(6'b000010, 0, 0, 1'b0);   // jump
    run_instr(6'b101011, 0, 2, 1'b1);   // sw with memory wait
    run_instr(6'b111111, 0, 0, 1'b0);   // illegal: sticky flag from here
    random_instrs(40);

    // Reset while a store waits on memory: drops MemWrite and State without a clock.
    cyc(6'd0, 1'b1, 0, 1'b1);
    cyc(6'b101011, 1'b1, 1, 1'b1);
    m_lop = 6'b101011;
    cyc(6'd0, 1'b1, 2, 1'b1);
    cyc(6'd0, 1'b0, 5, 1'b1);
    @(negedge clk);
    #2;
    check("store_memwrite_before_reset", {7'd0, MemWrite}, 8'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_memwrite", {7'd0, MemWrite}, 8'd0);
    check("async_reset_state", {4'd0, State}, 8'd0);
    check("async_reset_illegal", {7'd0, IllegalOp}, 8'd0);
    m_ill = 1'b0;
    m_lop = 6'd0;
    cyc(6'd0, 1'b0, 0, 1'b0);

    random_instrs(40);
    run_instr(6'b010101, 0, 0, 1'b0);
    random_instrs(5);

    @(posedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
